controle_multiciclo: RTL and testbench

//  Main control FSM for the multicycle RV32I datapath; successor of the single-cycle decoder.

---
 rtl/controle_multiciclo_pkg.sv | 74 +++++++
 rtl/controle_multiciclo_contador_espera.sv | 29 ++
 rtl/controle_multiciclo.sv | 188 ++++++++++++++++++
 tb/tb_controle_multiciclo.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/controle_multiciclo_pkg.sv
// Shared definitions for the multicycle RV32I control: opcodes, state set,
// datapath select encodings and the control-word struct driven by the FSM.
package controle_multiciclo_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [1:0] M2R_ALUOUT = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] A_PC       = 2'b00;
    localparam logic [1:0] A_PCANT    = 2'b01;
    localparam logic [1:0] A_REGA     = 2'b10;

    localparam logic [1:0] B_REGB     = 2'b00;
    localparam logic [1:0] B_CONST4   = 2'b01;
    localparam logic [1:0] B_IMM      = 2'b10;

    localparam logic [1:0] PC_ALU     = 2'b00;
    localparam logic [1:0] PC_ALUOUT  = 2'b01;
    localparam logic [1:0] PC_ALU_AL  = 2'b10;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_SUB    = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_LUI    = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_MEMADDR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXEC_R, S_EXEC_I, S_LUI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_ILLEGAL
    } estado_t;

    typedef struct packed {
        logic       escreve_ir;
        logic       escreve_pc;
        logic       escreve_pc_cond;
        logic       iou_d;
        logic       le_mem;
        logic       escreve_mem;
        logic       escreve_reg;
        logic [1:0] mem2reg;
        logic [1:0] orig_a;
        logic [1:0] orig_b;
        logic [1:0] alu_op;
        logic [1:0] orig_pc;
    } ctrl_t;

    localparam ctrl_t CTRL_NOP = '0;

    function automatic estado_t decode_next(input logic [6:0] opc);
        case (opc)
            OPC_LOAD, OPC_STORE: return S_MEMADDR;
            OPC_RTYPE:           return S_EXEC_R;
            OPC_OPIMM:           return S_EXEC_I;
            OPC_LUI:             return S_LUI;
            OPC_BRANCH:          return S_BRANCH;
            OPC_JAL:             return S_JAL;
            OPC_JALR:            return S_JALR;
            default:             return S_ILLEGAL;
        endcase
    endfunction

    function automatic logic is_mem_state(input estado_t s);
        return (s == S_FETCH) || (s == S_MEMREAD) || (s == S_MEMWRITE);
    endfunction

endpackage

// File: rtl/controle_multiciclo_contador_espera.sv
// Fixed-latency wait-state counter: done rises in the MEM_LAT-th cycle of an
// access; clear restarts the count whenever the FSM changes state.
module contador_espera #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic iCLK,
    input  logic iRST_n,
    input  logic clear,
    input  logic en,
    output logic done
);

    localparam int unsigned CW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CW-1:0] ULTIMO = CW'(MEM_LAT - 1);

    logic [CW-1:0] wcnt;

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n)
            wcnt <= '0;
        else if (clear)
            wcnt <= '0;
        else if (en && wcnt != ULTIMO)
            wcnt <= wcnt + 1'b1;
    end

    assign done = en && (wcnt == ULTIMO);

endmodule

// File: rtl/controle_multiciclo.sv
// Main control FSM of the multicycle RV32I datapath: sequences FETCH/DECODE/
// EXEC/MEM/WB, stalls on memory, traps unknown opcodes and counts retirements.
module controle_multiciclo
    import controle_multiciclo_pkg::*;
#(
    parameter bit          USE_MEM_READY = 1'b1,
    parameter int unsigned MEM_LAT       = 1,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             iCLK,
    input  logic             iRST_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             EscreveIR,
    output logic             EscrevePC,
    output logic             EscrevePCCond,
    output logic             IouD,
    output logic             LeMem,
    output logic             EscreveMem,
    output logic             EscreveReg,
    output logic [1:0]       Mem2Reg,
    output logic [1:0]       OrigAULA,
    output logic [1:0]       OrigBULA,
    output logic [1:0]       ALUOp,
    output logic [1:0]       OrigPC,
    output logic             instr_done,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instret
);

    estado_t state, state_next;
    ctrl_t   ctrl;
    logic    mem_done;
    logic    em_acesso;

    assign em_acesso = is_mem_state(state);

    generate
        if (USE_MEM_READY) begin : g_ready
            assign mem_done = mem_ready;
        end else begin : g_lat
            logic wclear;
            assign wclear = (state_next != state);
            contador_espera #(.MEM_LAT(MEM_LAT)) u_espera (
                .iCLK   (iCLK),
                .iRST_n (iRST_n),
                .clear  (wclear),
                .en     (em_acesso),
                .done   (mem_done)
            );
        end
    endgenerate

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n)
            state <= S_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     state_next = S_FETCH;
            S_FETCH:    if (mem_done) state_next = S_DECODE;
            S_DECODE:   state_next = decode_next(opcode);
            S_MEMADDR:  state_next = (opcode == OPC_STORE) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (mem_done) state_next = S_MEMWB;
            S_MEMWRITE: if (mem_done) state_next = S_FETCH;
            S_EXEC_R, S_EXEC_I, S_LUI:
                        state_next = S_ALUWB;
            S_MEMWB, S_ALUWB, S_BRANCH, S_JAL, S_JALR:
                        state_next = S_FETCH;
            S_ILLEGAL:  state_next = S_ILLEGAL;
            default:    state_next = S_IDLE;
        endcase
    end

    // Only FETCH looks at mem_done: IR and PC are loaded in the completing cycle.
    always_comb begin
        ctrl = CTRL_NOP;
        case (state)
            S_FETCH: begin
                ctrl.le_mem = 1'b1;
                ctrl.orig_a = A_PC;
                ctrl.orig_b = B_CONST4;
                ctrl.alu_op = ALU_ADD;
                if (mem_done) begin
                    ctrl.escreve_ir = 1'b1;
                    ctrl.escreve_pc = 1'b1;
                    ctrl.orig_pc    = PC_ALU;
                end
            end
            S_DECODE: begin
                ctrl.orig_a = A_PCANT;
                ctrl.orig_b = B_IMM;
                ctrl.alu_op = ALU_ADD;
            end
            S_MEMADDR: begin
                ctrl.orig_a = A_REGA;
                ctrl.orig_b = B_IMM;
                ctrl.alu_op = ALU_ADD;
            end
            S_MEMREAD: begin
                ctrl.iou_d  = 1'b1;
                ctrl.le_mem = 1'b1;
            end
            S_MEMWB: begin
                ctrl.escreve_reg = 1'b1;
                ctrl.mem2reg     = M2R_MDR;
            end
            S_MEMWRITE: begin
                ctrl.iou_d       = 1'b1;
                ctrl.escreve_mem = 1'b1;
            end
            S_EXEC_R: begin
                ctrl.orig_a = A_REGA;
                ctrl.orig_b = B_REGB;
                ctrl.alu_op = ALU_FUNCT;
            end
            S_EXEC_I: begin
                ctrl.orig_a = A_REGA;
                ctrl.orig_b = B_IMM;
                ctrl.alu_op = ALU_ADD;
            end
            S_LUI: begin
                ctrl.orig_b = B_IMM;
                ctrl.alu_op = ALU_LUI;
            end
            S_ALUWB: begin
                ctrl.escreve_reg = 1'b1;
                ctrl.mem2reg     = M2R_ALUOUT;
            end
            S_BRANCH: begin
                ctrl.orig_a          = A_REGA;
                ctrl.orig_b          = B_REGB;
                ctrl.alu_op          = ALU_SUB;
                ctrl.escreve_pc_cond = 1'b1;
                ctrl.orig_pc         = PC_ALUOUT;
            end
            S_JAL: begin
                ctrl.escreve_reg = 1'b1;
                ctrl.mem2reg     = M2R_PC;
                ctrl.escreve_pc  = 1'b1;
                ctrl.orig_pc     = PC_ALUOUT;
            end
            S_JALR: begin
                ctrl.orig_a      = A_REGA;
                ctrl.orig_b      = B_IMM;
                ctrl.alu_op      = ALU_ADD;
                ctrl.escreve_reg = 1'b1;
                ctrl.mem2reg     = M2R_PC;
                ctrl.escreve_pc  = 1'b1;
                ctrl.orig_pc     = PC_ALU_AL;
            end
            default: ;
        endcase
    end

    assign EscreveIR     = ctrl.escreve_ir;
    assign EscrevePC     = ctrl.escreve_pc;
    assign EscrevePCCond = ctrl.escreve_pc_cond;
    assign IouD          = ctrl.iou_d;
    assign LeMem         = ctrl.le_mem;
    assign EscreveMem    = ctrl.escreve_mem;
    assign EscreveReg    = ctrl.escreve_reg;
    assign Mem2Reg       = ctrl.mem2reg;
    assign OrigAULA      = ctrl.orig_a;
    assign OrigBULA      = ctrl.orig_b;
    assign ALUOp         = ctrl.alu_op;
    assign OrigPC        = ctrl.orig_pc;

    // Retirement is the last cycle of an instruction: the FSM is about to re-enter FETCH.
    assign instr_done = (state != S_IDLE) && (state != S_FETCH) && (state_next == S_FETCH);

    always_ff @(posedge iCLK or negedge iRST_n) begin
        if (!iRST_n) begin
            instret    <= '0;
            illegal_op <= 1'b0;
        end else begin
            if (instr_done)
                instret <= instret + CNT_W'(1);
            if (state == S_ILLEGAL)
                illegal_op <= 1'b1;
        end
    end

endmodule

// File: tb/tb_controle_multiciclo.sv
// Randomized scoreboard bench: one DUT in ready-handshake mode, one in
// fixed-latency mode, each checked per retired instruction against a phase model.
module tb_controle_multiciclo;

    localparam int N   = 40;
    localparam int LAT = 3;

    typedef struct {
        int         cyc;
        int         nreg;
        int         nwr;
        logic [1:0] wb;
        int         npc;
        logic [1:0] pcsel;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic [1:0][6:0]  opc;
    logic [1:0]       rdy;
    logic [1:0]       eir, epc, epcc, iord, lem, emem, ereg, done, ill;
    logic [1:0][1:0]  m2r, oa, ob, aop, pcsel;
    logic [1:0][31:0] icnt;

    controle_multiciclo #(.USE_MEM_READY(1'b1), .MEM_LAT(1), .CNT_W(32)) u_rdy (
        .iCLK(clk), .iRST_n(rst_n), .opcode(opc[0]), .mem_ready(rdy[0]),
        .EscreveIR(eir[0]), .EscrevePC(epc[0]), .EscrevePCCond(epcc[0]), .IouD(iord[0]),
        .LeMem(lem[0]), .EscreveMem(emem[0]), .EscreveReg(ereg[0]), .Mem2Reg(m2r[0]),
        .OrigAULA(oa[0]), .OrigBULA(ob[0]), .ALUOp(aop[0]), .OrigPC(pcsel[0]),
        .instr_done(done[0]), .illegal_op(ill[0]), .instret(icnt[0]));

    controle_multiciclo #(.USE_MEM_READY(1'b0), .MEM_LAT(LAT), .CNT_W(32)) u_lat (
        .iCLK(clk), .iRST_n(rst_n), .opcode(opc[1]), .mem_ready(rdy[1]),
        .EscreveIR(eir[1]), .EscrevePC(epc[1]), .EscrevePCCond(epcc[1]), .IouD(iord[1]),
        .LeMem(lem[1]), .EscreveMem(emem[1]), .EscreveReg(ereg[1]), .Mem2Reg(m2r[1]),
        .OrigAULA(oa[1]), .OrigBULA(ob[1]), .ALUOp(aop[1]), .OrigPC(pcsel[1]),
        .instr_done(done[1]), .illegal_op(ill[1]), .instret(icnt[1]));

    int nchk = 0, nfail = 0;
    exp_t q0[$], q1[$];
    int prev[2], kc[2], wcur[2], wfq[2], wmq[2], issued[2], rc[2];
    int pat;
    bit force_lw = 1'b0;
    logic [6:0] optab [8] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
                              7'b0110111, 7'b1100011, 7'b1101111, 7'b1100111};

    task automatic chk(input string name, input int d, input int act, input int req);
        nchk++;
        if (act != req) begin
            nfail++;
            $display("FAIL %s[dut%0d]: actual %0d, required %0d", name, d, act, req);
        end
    endtask

    // Instruction = fetch (1+wf) + decode + its own phases; data accesses take 1+wm.
    function automatic exp_t model(input logic [6:0] op, input int wf, input int wm);
        exp_t e = '{default: 0};
        int f = 1 + wf;
        case (op)
            7'b0000011: begin e.cyc = f + 2 + (1 + wm) + 1; e.nreg = 1; e.wb = 2'b01; end
            7'b0100011: begin e.cyc = f + 2 + (1 + wm); e.nwr = 1 + wm; end
            7'b0110011, 7'b0010011, 7'b0110111:
                        begin e.cyc = f + 3; e.nreg = 1; e.wb = 2'b00; end
            7'b1100011: begin e.cyc = f + 2; e.npc = 1; e.pcsel = 2'b01; end
            7'b1101111: begin e.cyc = f + 2; e.nreg = 1; e.wb = 2'b10; e.npc = 1; e.pcsel = 2'b01; end
            default:    begin e.cyc = f + 2; e.nreg = 1; e.wb = 2'b10; e.npc = 1; e.pcsel = 2'b10; end
        endcase
        return e;
    endfunction

    task automatic issue(input int d);
        logic [6:0] op;
        int wf, wm;
        if (force_lw && d == 0) begin
            op = 7'b0000011; wf = 0; wm = 50;
        end else if (issued[d] >= N) begin
            op = 7'h7f; wf = 0; wm = 0;
        end else begin
            op = optab[$urandom_range(0, 7)];
            wf = (d == 0) ? int'($urandom_range(0, 3)) : LAT - 1;
            wm = (d == 0) ? int'($urandom_range(0, 3)) : LAT - 1;
        end
        opc[d] = op; wfq[d] = wf; wmq[d] = wm; issued[d]++;
        if (op != 7'h7f) begin
            if (d == 0) q0.push_back(model(op, wf, wm));
            else        q1.push_back(model(op, wf, wm));
        end
    endtask

    // Driver: a new access starts when the strobe pattern changes; mem_ready is random outside accesses.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            pat = (lem[d] && !iord[d]) ? 1 : (lem[d] && iord[d]) ? 2 : emem[d] ? 3 : 0;
            if (!rst_n) begin
                prev[d] = 0;
            end else begin
                if (pat != 0 && pat != prev[d]) begin
                    kc[d] = 0;
                    if (pat == 1) begin
                        issue(d);
                        wcur[d] = wfq[d];
                    end else begin
                        wcur[d] = wmq[d];
                    end
                end
                rdy[d] = (pat != 0) ? (kc[d] >= wcur[d]) : 1'($urandom_range(0, 1));
                if (pat != 0) kc[d]++;
                prev[d] = pat;
            end
        end
    end

    int cyc[2], nreg[2], nwr[2], nir[2], npc[2];
    logic [1:0] wbs[2], pcs[2];
    bit inst[2];

    // Monitor: accumulate per-instruction observations, compare on instr_done.
    always begin
        @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
                inst[d] = 1'b0;
            end else begin
                if (!inst[d] && lem[d] && !iord[d]) begin
                    inst[d] = 1'b1;
                    cyc[d] = 0; nreg[d] = 0; nwr[d] = 0; nir[d] = 0; npc[d] = 0;
                end
                if (inst[d]) begin
                    cyc[d]++;
                    if (ereg[d]) begin nreg[d]++; wbs[d] = m2r[d]; end
                    if (emem[d]) nwr[d]++;
                    if (eir[d]) nir[d]++;
                    if ((epc[d] || epcc[d]) && !eir[d]) begin npc[d]++; pcs[d] = pcsel[d]; end
                end
                if (done[d]) begin
                    exp_t e;
                    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
                        chk("unexpected_retire", d, 1, 0);
                    end else begin
                        if (d == 0) e = q0.pop_front(); else e = q1.pop_front();
                        chk("cycles", d, cyc[d], e.cyc);
                        chk("reg_writes", d, nreg[d], e.nreg);
                        chk("mem_write_cycles", d, nwr[d], e.nwr);
                        chk("ir_loads", d, nir[d], 1);
                        chk("pc_writes", d, npc[d], e.npc);
                        if (e.nreg > 0) chk("mem2reg", d, int'(wbs[d]), int'(e.wb));
                        if (e.npc > 0)  chk("origpc", d, int'(pcs[d]), int'(e.pcsel));
                        chk("instret", d, int'(icnt[d]), rc[d]);
                    end
                    rc[d]++;
                    inst[d] = 1'b0;
                end
            end
        end
    end

    function automatic int outs(input int d);
        return int'({eir[d], epc[d], epcc[d], iord[d], lem[d], emem[d], ereg[d], done[d],
                     ill[d], m2r[d], oa[d], ob[d], aop[d], pcsel[d]});
    endfunction

    initial begin
        int c;
        rst_n = 1'b0;
        opc = '0;
        rdy = '0;
        for (int d = 0; d < 2; d++) begin issued[d] = 0; rc[d] = 0; prev[d] = 0; end
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_outputs", d, outs(d), 0);
            chk("reset_instret", d, int'(icnt[d]), 0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        c = 0;
        while (c < 20000 && !(rc[0] >= N && rc[1] >= N && ill[0] && ill[1])) begin
            @(negedge clk);
            c++;
        end
        repeat (4) @(negedge clk);
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("retired", d, rc[d], N);
            chk("illegal_op", d, int'(ill[d]), 1);
            chk("illegal_strobes", d, int'({eir[d], epc[d], epcc[d], lem[d], emem[d], ereg[d]}), 0);
            chk("final_instret", d, int'(icnt[d]), N);
        end

        // Reset in the middle of a long load data access.
        @(negedge clk);
        rst_n = 1'b0;
        force_lw = 1'b1;
        q0.delete(); q1.delete();
        rc[0] = 0; rc[1] = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        c = 0;
        while (c < 60 && !(lem[0] && iord[0])) begin
            @(negedge clk);
            c++;
        end
        #2;
        chk("reach_memread", 0, int'(lem[0] && iord[0]), 1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs", 0, outs(0), 0);
        chk("abort_instret", 0, int'(icnt[0]), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end

endmodule
